// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared FSM state, reference table constants and dwell counter width for the truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    localparam logic [7:0] TT_XOR_XNOR = 8'h96;
    localparam logic [7:0] TT_NOR_NAND = 8'h71;
    localparam int         CNT_W       = 8;

endpackage

// File: rtl/tt_dwell_cnt.sv
// tt_dwell_cnt: clear/enable dwell counter that wraps to zero and flags its terminal count at DWELL-1.
module tt_dwell_cnt import tt_sweep_pkg::*; #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc = cnt_q == CNT_W'(DWELL - 1);

    always_comb cnt_d = clr ? '0 : en ? (tc ? '0 : cnt_q + CNT_W'(1)) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input row of a combinational table block in order and captures its truth table.
// Define TT_SWEEP_CHECK_EN to compare the capture against EXP and report pass/err_count.
module truth_table_sweeper import tt_sweep_pkg::*; #(
    parameter int                 N_IN  = 3,
    parameter int                 DWELL = 4,
    parameter logic [2**N_IN-1:0] EXP   = TT_XOR_XNOR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [N_IN-1:0]    dut_in,
    input  logic               dut_y,
    output logic               busy,
    output logic               done,
    output logic [2**N_IN-1:0] result,
    output logic               pass,
    output logic [N_IN:0]      err_count
);

    localparam int ROWS = 2**N_IN;
    localparam int EW   = N_IN + 1;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [ROWS-1:0] result_q, result_d;
    logic            launch, last, tc;

    assign launch = (state_q == IDLE) && start;
    assign last   = idx_q == N_IN'(ROWS - 1);

    tt_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .en    (state_q == APPLY),
        .tc    (tc)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dut_in_d = dut_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = APPLY;
                idx_d    = '0;
                dut_in_d = '0;
                busy_d   = 1'b1;
                result_d = '0;
            end
            APPLY: if (tc) begin
                result_d[idx_q] = dut_y;
                if (last) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    dut_in_d = '0;
                end else begin
                    idx_d    = idx_q + N_IN'(1);
                    dut_in_d = idx_q + N_IN'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign dut_in = dut_in_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

`ifdef TT_SWEEP_CHECK_EN
    logic          capture;
    logic          pass_q, pass_d;
    logic [EW-1:0] err_q, err_d;

    assign capture = (state_q == APPLY) && tc;

    // pass is settled on the last capture edge so it is already valid while done is high
    always_comb begin
        pass_d = launch ? 1'b0 : (capture && last) ? (result_d == EXP) : pass_q;
        err_d  = launch ? '0 : capture ? err_q + EW'(dut_y != EXP[idx_q]) : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
            err_q  <= '0;
        end else begin
            pass_q <= pass_d;
            err_q  <= err_d;
        end
    end

    assign pass      = pass_q;
    assign err_count = err_q;
`else
    // EXP only matters to the comparison, which this build leaves out
    assign pass      = 1'b0 & (^EXP);
    assign err_count = '0;
`endif

endmodule
